// File: rtl/vec_mem_pkg.sv
// Shared encodings and sizing defaults for the vector memory arbiter.
// The vector LSU reuses the burst/gap defaults when sizing vl into beats.
package vec_mem_pkg;

    localparam int unsigned MAX_BURST_DEF = 16;
    localparam int unsigned GAP_MAX_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    function automatic owner_e state_owner(input arb_state_e s);
        case (s)
            ST_GNT0: return OWN_M0;
            ST_GNT1: return OWN_M1;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vec_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word memory,
// with bounded locked bursts for the vector LSU (master 1).
module vec_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned GAP_MAX   = GAP_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned GW = $clog2(GAP_MAX + 1);

    arb_state_e    state_q;
    logic          rr_last_q;
    logic [BW-1:0] beat_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [BW-1:0] beat_cnt_d;

    assign beat_cnt_d = beat_cnt_q + BW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // On a tie the master that did not complete last wins.
                    if (m0_valid && (!m1_valid || rr_last_q)) begin
                        state_q <= ST_GNT0;
                    end else if (m1_valid) begin
                        state_q    <= ST_GNT1;
                        beat_cnt_q <= '0;
                        gap_cnt_q  <= '0;
                    end
                end
                ST_GNT0: begin
                    if (mem_ready) begin
                        rr_last_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_GNT1: begin
                    if (mem_ready) begin
                        beat_cnt_q <= beat_cnt_d;
                        rr_last_q  <= 1'b1;
                        gap_cnt_q  <= '0;
                        if (!m1_lock || beat_cnt_d == BW'(MAX_BURST)) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!m1_valid) begin
                        if (!m1_lock || gap_cnt_q == GW'(GAP_MAX - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GW'(1);
                        end
                    end else begin
                        gap_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        unique case (state_q)
            ST_GNT0: begin
                mem_valid = m0_valid;
                mem_instr = m0_instr;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_wstrb = m0_wstrb;
                m0_ready  = mem_ready;
            end
            ST_GNT1: begin
                mem_valid = m1_valid;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_wstrb = m1_wstrb;
                m1_ready  = mem_ready;
            end
            default: ;
        endcase
    end

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;
    assign owner    = state_owner(state_q);

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: two master drivers, a one-cycle memory, and a
// tenure-level reference model of who should own the memory each cycle.
module tb_vec_mem_arbiter;
    import vec_mem_pkg::*;

    typedef logic [71:0] v_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [3:0]  delay;
    } req_t;

    localparam int unsigned MAXB = 16;
    localparam int unsigned GAPM = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m0_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_wstrb = '0;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  owner;
    logic        mem_load = 1'b1;

    always #5 clk = ~clk;

    vec_mem_arbiter #(.MAX_BURST(MAXB), .GAP_MAX(GAPM)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        logic [7:0] b0;
        b0 = a[7:0] - 8'h1F;
        return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // One-cycle memory: ready the cycle after it first sees mem_valid; ignores arbiter reset.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(32'(i * 4));
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_valid && !mem_ready;
            if (mem_valid && !mem_ready) begin
                mem_rdata <= mem[mem_addr[9:2]];
                mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~bmask(mem_wstrb))
                                    | (mem_wdata & bmask(mem_wstrb));
            end
        end
    end

    logic [31:0] ref_mem [256];
    req_t  q0[$], q1[$];
    req_t  r0, r1;
    int    order[$];
    logic [31:0] rd0_log[$], rd1_log[$];
    logic  got0 = 1'b0, got1 = 1'b0;
    int    wait0 = 0, wait1 = 0;
    logic  rst_req = 1'b1, load_req = 1'b1, lock_req = 1'b0;
    int    checks = 0, errors = 0;

    // Reference: -1 nobody, 0 core, 1 vector; last_m is the last master to complete.
    int cur_m = -1, last_m = 1, beats = 0, idle_run = 0;

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit quiet();
        return q0.size() == 0 && q1.size() == 0 && !m0_valid && !m1_valid
            && !got0 && !got1 && cur_m < 0;
    endfunction

    task automatic push(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic [3:0] d);
        req_t r;
        r.addr = a; r.wdata = wd; r.wstrb = s; r.delay = d;
        r.instr = (m == 0 && s == 4'd0) ? 1'($urandom()) : 1'b0;
        if (m == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic observe();
        logic [1:0]  exp_own;
        logic        exp_mv;
        logic [68:0] exp_bus;
        logic [7:0]  idx;
        exp_own = (cur_m == 0) ? 2'b01 : (cur_m == 1) ? 2'b10 : 2'b00;
        exp_mv  = (cur_m == 0) ? m0_valid : (cur_m == 1) ? m1_valid : 1'b0;
        exp_bus = (cur_m == 0) ? {m0_instr, m0_addr, m0_wdata, m0_wstrb}
                : (cur_m == 1) ? {1'b0, m1_addr, m1_wdata, m1_wstrb} : '0;
        chk("owner", v_t'(owner), v_t'(exp_own));
        chk("mem_valid", v_t'(mem_valid), v_t'(exp_mv));
        chk("mem_bus", v_t'({mem_instr, mem_addr, mem_wdata, mem_wstrb}), v_t'(exp_bus));
        chk("ready_route", v_t'({m0_ready, m1_ready}),
            v_t'({cur_m == 0 && mem_ready, cur_m == 1 && mem_ready}));
        if (m0_valid && m0_ready) begin
            got0 = 1'b1; order.push_back(0); idx = r0.addr[9:2];
            if (r0.wstrb == 4'd0) begin
                chk("m0_rdata", v_t'(m0_rdata), v_t'(ref_mem[idx]));
                rd0_log.push_back(m0_rdata);
            end else ref_mem[idx] = (ref_mem[idx] & ~bmask(r0.wstrb)) | (r0.wdata & bmask(r0.wstrb));
        end
        if (m1_valid && m1_ready) begin
            got1 = 1'b1; order.push_back(1); idx = r1.addr[9:2];
            if (r1.wstrb == 4'd0) begin
                chk("m1_rdata", v_t'(m1_rdata), v_t'(ref_mem[idx]));
                rd1_log.push_back(m1_rdata);
            end else ref_mem[idx] = (ref_mem[idx] & ~bmask(r1.wstrb)) | (r1.wdata & bmask(r1.wstrb));
        end
        if (reset) begin
            cur_m = -1; last_m = 1;
        end else if (cur_m < 0) begin
            if (m0_valid && m1_valid) cur_m = (last_m == 0) ? 1 : 0;
            else if (m0_valid) cur_m = 0;
            else if (m1_valid) cur_m = 1;
            if (cur_m == 1) begin beats = 0; idle_run = 0; end
        end else if (cur_m == 0) begin
            if (mem_ready) begin last_m = 0; cur_m = -1; end
        end else begin
            if (mem_ready) begin
                beats++; last_m = 1; idle_run = 0;
                if (!m1_lock || beats == int'(MAXB)) cur_m = -1;
            end else if (!m1_valid) begin
                if (!m1_lock || idle_run == int'(GAPM) - 1) cur_m = -1;
                else idle_run++;
            end else idle_run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset = rst_req; mem_load = load_req; m1_lock = lock_req;
        if (got0) begin
            got0 = 1'b0; m0_valid = 1'b0; wait0 = 0;
            m0_addr = $urandom(); m0_wdata = $urandom();
            m0_wstrb = 4'($urandom()); m0_instr = 1'($urandom());
        end else if (!m0_valid && q0.size() > 0) begin
            if (wait0 >= int'(q0[0].delay)) begin
                r0 = q0.pop_front(); wait0 = 0; m0_valid = 1'b1;
                m0_addr = r0.addr; m0_wdata = r0.wdata; m0_wstrb = r0.wstrb; m0_instr = r0.instr;
            end else wait0++;
        end
        if (got1) begin
            got1 = 1'b0; m1_valid = 1'b0; wait1 = 0;
            m1_addr = $urandom(); m1_wdata = $urandom(); m1_wstrb = 4'($urandom());
        end else if (!m1_valid && q1.size() > 0) begin
            if (wait1 >= int'(q1[0].delay)) begin
                r1 = q1.pop_front(); wait1 = 0; m1_valid = 1'b1;
                m1_addr = r1.addr; m1_wdata = r1.wdata; m1_wstrb = r1.wstrb;
            end else wait1++;
        end
        @(negedge clk);
        observe();
    endtask

    task automatic settle(input string tag, input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin step(); n++; end
        chk({tag, "_settle"}, v_t'(quiet()), v_t'(1));
    endtask

    task automatic clear_logs();
        order.delete(); rd0_log.delete(); rd1_log.delete();
    endtask

    initial begin
        int n;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(32'(i * 4));

        step(); step();
        chk("reset_owner", v_t'({owner, mem_valid, m0_ready, m1_ready}), v_t'(0));
        rst_req = 1'b0; load_req = 1'b0;

        // Tie straight after reset: core first, then vector.
        clear_logs();
        push(0, 32'h100, 32'h0, 4'd0, 4'd0);
        push(1, 32'h104, 32'h0, 4'd0, 4'd0);
        settle("tie", 50);
        chk("tie_count", v_t'(order.size()), v_t'(2));
        chk("tie_first", v_t'(order[0]), v_t'(0));
        chk("tie_second", v_t'(order[1]), v_t'(1));

        // Continuous requests from both alternate.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push(0, 32'(32'h180 + i * 4), 32'h0, 4'd0, 4'd0);
            push(1, 32'(32'h1C0 + i * 4), 32'h0, 4'd0, 4'd0);
        end
        settle("alt", 100);
        chk("alt_count", v_t'(order.size()), v_t'(8));
        for (int i = 0; i < 8; i++) chk("alt_order", v_t'(order[i]), v_t'(i % 2));

        // Locked burst of 16 reads, core waiting, forced release after beat 16.
        clear_logs();
        lock_req = 1'b1;
        for (int i = 0; i < 16; i++) push(1, 32'(32'h320 + i * 4), 32'h0, 4'd0, 4'd0);
        push(0, 32'h200, 32'h0, 4'd0, 4'd2);
        settle("burst", 200);
        n = 0;
        while (n < order.size() && order[n] == 1) n++;
        chk("burst_beats", v_t'(n), v_t'(16));
        chk("burst_total", v_t'(order.size()), v_t'(17));
        chk("burst_rdata0", v_t'(rd1_log[0]), v_t'(32'h01020304));

        // Locked tenure released by an idle gap; the waiting core goes next.
        clear_logs();
        push(1, 32'h240, 32'h0, 4'd0, 4'd0);
        push(1, 32'h244, 32'h0, 4'd0, 4'd3);
        push(0, 32'h248, 32'h0, 4'd0, 4'd0);
        settle("gap", 100);
        chk("gap_count", v_t'(order.size()), v_t'(3));
        chk("gap_order", v_t'({order[0][1:0], order[1][1:0], order[2][1:0]}), v_t'(6'b01_00_01));
        lock_req = 1'b0;

        // Vector halfword write, read back by the core.
        clear_logs();
        push(1, 32'h3BC, 32'hDEADBEEF, 4'b0011, 4'd0);
        push(0, 32'h3BC, 32'h0, 4'd0, 4'd4);
        settle("wr", 100);
        w = pat(32'h3BC);
        chk("wr_count", v_t'(order.size()), v_t'(2));
        chk("wr_half", v_t'(rd0_log[0]), v_t'({w[31:16], 16'hBEEF}));

        // Reset during the first granted cycle of a vector access.
        clear_logs();
        push(1, 32'h300, 32'h0, 4'd0, 4'd0);
        step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        push(0, 32'h304, 32'h0, 4'd0, 4'd0);
        step();
        chk("stray_ready", v_t'({mem_ready, m1_ready, owner}), v_t'(4'b1000));
        settle("rst", 100);
        chk("rst_count", v_t'(order.size()), v_t'(2));
        chk("rst_tie_m0", v_t'(order[0]), v_t'(0));

        // Randomised traffic, alternating lock on and off per chunk.
        for (int k = 0; k < 6; k++) begin
            lock_req = k[0];
            for (int j = 0; j < 10; j++) begin
                for (int m = 0; m < 2; m++) begin
                    push(m, {22'd0, 8'($urandom_range(0, 255)), 2'd0}, $urandom(),
                         ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                         4'($urandom_range(0, 3)));
                end
            end
            settle("rand", 2000);
        end
        lock_req = 1'b0;

        n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        chk("mem_image", v_t'(n), v_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
